// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: load-use interlock, MDU front-end stall, branch flush,
// plus a saturating count of front-end stall cycles.
module hazard_ctrl_unit #(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int MDU_LAT  = 4,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_ex_mem_read,
  input  logic [REG_AW-1:0] id_ex_rt,
  input  logic [REG_AW-1:0] if_id_rs,
  input  logic [REG_AW-1:0] if_id_rt,
  input  logic              if_id_uses_rt,
  input  logic              mdu_start,
  input  logic              branch_taken,
  output logic              pc_en,
  output logic              if_id_en,
  output logic              id_ex_bubble,
  output logic              if_id_flush,
  output logic              busy,
  output logic [CNT_W-1:0]  stall_cycles
);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] LOAD_STALL = 2'd1;
  localparam logic [1:0] MDU_BUSY   = 2'd2;

  // Four bits so the down-counter can hold MDU_LAT-1 for MDU_LAT up to 15.
  localparam int CW = 4;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic             hazard;

  assign hazard = id_ex_mem_read && (id_ex_rt != '0) &&
                  ((id_ex_rt == if_id_rs) || (if_id_uses_rt && (id_ex_rt == if_id_rt)));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    // Outputs hold their idle values for the whole reset window, whatever the inputs.
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
          end else if (hazard) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_bubble = 1'b1;
            if (LOAD_LAT > 1) begin
              state_d = LOAD_STALL;
              cnt_d   = CW'(LOAD_LAT - 1);
            end
          end else if (mdu_start) begin
            state_d = MDU_BUSY;
            cnt_d   = CW'(MDU_LAT - 1);
          end
        end
        LOAD_STALL, MDU_BUSY: begin
          pc_en        = 1'b0;
          if_id_en     = 1'b0;
          id_ex_bubble = 1'b1;
          cnt_d        = cnt_q - 1'b1;
          if (cnt_q == CW'(1)) state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (!pc_en && (stall_cycles_q != '1)) stall_cycles_d = stall_cycles_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign busy         = (state_q != IDLE);
  assign stall_cycles = stall_cycles_q;

endmodule
